// File: rtl/bit_serialiser.sv
// Parallel-to-serial stage feeding SequenceRecogniser: WIDTH-bit words in,
// LSB-first bit stream out, with a one-word pending buffer for gapless streaming.
module bit_serialiser #(
  parameter int   WIDTH      = 7,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clock,
  input  logic             nReset,
  input  logic [WIDTH-1:0] wordIn,
  input  logic             wordValid,
  output logic             wordReady,
  output logic             dataOut,
  output logic             bitValid,
  output logic             lastBit,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] pend;
  logic             pendValid;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             atLast;

  // Handshake: a word transfers on a rising edge where wordValid and wordReady
  // are both high; the source must hold wordIn stable until that edge.
  assign wordReady = nReset & ~pendValid;
  assign accept    = wordValid & wordReady;
  assign atLast    = (state == SHIFT) && (cnt == CW'(WIDTH - 1));

  assign dataOut  = (state == SHIFT) ? shreg[0] : IDLE_LEVEL;
  assign bitValid = (state == SHIFT);
  assign lastBit  = atLast;
  assign busy     = (state == SHIFT) | pendValid;

  always_ff @(posedge clock) begin
    if (!nReset) begin
      state     <= IDLE;
      shreg     <= '0;
      pend      <= '0;
      pendValid <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg <= wordIn;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (!atLast) begin
            shreg <= shreg >> 1;
            cnt   <= cnt + CW'(1);
            if (accept) begin
              pend      <= wordIn;
              pendValid <= 1'b1;
            end
          end else if (pendValid) begin
            // wordReady is low here, so no new word can collide with the reload.
            shreg     <= pend;
            cnt       <= '0;
            pendValid <= 1'b0;
          end else if (accept) begin
            shreg <= wordIn;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serialiser.sv
// Scoreboard bench for bit_serialiser: accepted words expand into an expected
// bit queue; monitors compare the serial stream and handshake every cycle.
module tb_bit_serialiser;

  localparam int W = 7;

  typedef struct packed {
    logic b;
    logic last;
  } exp_bit_t;

  logic         clock = 1'b0;
  logic         nReset;
  logic [W-1:0] wordIn;
  logic         wordValid;
  logic         wordReady, dataOut, bitValid, lastBit, busy;

  logic [0:0]   wordIn1;
  logic         wordValid1;
  logic         wordReady1, dataOut1, bitValid1, lastBit1, busy1;

  exp_bit_t exp_q[$];
  exp_bit_t exp1_q[$];
  int       checks = 0;
  int       errors = 0;
  logic     monEn = 1'b0;
  logic     rdyPrev = 1'b0;
  logic     rdyPrev1 = 1'b0;

  always #5 clock = ~clock;

  bit_serialiser #(.WIDTH(W), .IDLE_LEVEL(1'b1)) u_dut (
    .clock(clock), .nReset(nReset), .wordIn(wordIn), .wordValid(wordValid),
    .wordReady(wordReady), .dataOut(dataOut), .bitValid(bitValid),
    .lastBit(lastBit), .busy(busy)
  );

  bit_serialiser #(.WIDTH(1), .IDLE_LEVEL(1'b1)) u_dut1 (
    .clock(clock), .nReset(nReset), .wordIn(wordIn1), .wordValid(wordValid1),
    .wordReady(wordReady1), .dataOut(dataOut1), .bitValid(bitValid1),
    .lastBit(lastBit1), .busy(busy1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each accepted word becomes its bits in LSB-first order.
  always @(posedge clock) begin
    if (!nReset) begin
      exp_q.delete();
      exp1_q.delete();
    end else begin
      if (wordValid && rdyPrev)
        for (int i = 0; i < W; i++) exp_q.push_back('{wordIn[i], i == W - 1});
      if (wordValid1 && rdyPrev1)
        exp1_q.push_back('{wordIn1[0], 1'b1});
    end
  end

  // The block holds at most one word beyond the one being shifted, so it is
  // ready exactly when no more than one word is outstanding.
  always @(negedge clock) begin
    int words;
    int words1;
    exp_bit_t e;
    rdyPrev  = wordReady;
    rdyPrev1 = wordReady1;
    if (monEn) begin
      words = 0;
      foreach (exp_q[i]) if (exp_q[i].last) words++;
      chk("wordReady", wordReady, nReset && words <= 1);
      chk("busy", busy, exp_q.size() != 0);
      chk("bitValid", bitValid, exp_q.size() != 0);
      if (bitValid && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("dataOut", dataOut, e.b);
        chk("lastBit", lastBit, e.last);
      end else if (!bitValid) begin
        chk("idleLevel", dataOut, 1'b1);
        chk("idleLastBit", lastBit, 1'b0);
      end

      words1 = exp1_q.size();
      chk("w1_wordReady", wordReady1, nReset && words1 <= 1);
      chk("w1_bitValid", bitValid1, words1 != 0);
      chk("w1_lastBit", lastBit1, bitValid1);
      if (bitValid1 && words1 != 0) begin
        e = exp1_q.pop_front();
        chk("w1_dataOut", dataOut1, e.b);
      end else if (!bitValid1) begin
        chk("w1_idleLevel", dataOut1, 1'b1);
      end
    end
  end

  task automatic send(input logic [W-1:0] w);
    int n = 0;
    wordIn    = w;
    wordValid = 1'b1;
    @(negedge clock);
    while (!wordReady && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: wordReady stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic send1(input logic b);
    int n = 0;
    wordIn1    = b;
    wordValid1 = 1'b1;
    @(negedge clock);
    while (!wordReady1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send1_timeout: wordReady stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    wordValid  = 1'b0;
    wordValid1 = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int n;
    nReset     = 1'b0;
    wordIn     = '0;
    wordValid  = 1'b0;
    wordIn1    = '0;
    wordValid1 = 1'b0;
    @(posedge clock);
    #1;
    monEn = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_dataOut", dataOut, 1'b1);
    chk("reset_bitValid", bitValid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_wordReady", wordReady, 1'b0);
    @(posedge clock);
    #1;
    nReset = 1'b1;
    idle(2);

    // Single word, then back-to-back, then three words to exercise backpressure.
    send(7'b0110110);
    idle(10);
    send(7'b0110110);
    send(7'b1111111);
    idle(16);
    send(7'h2A);
    send(7'h55);
    send(7'h13);
    idle(25);

    // Bypass path: offer each new word only during a lastBit cycle.
    send(W'($urandom));
    wordValid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      @(negedge clock);
      while (!lastBit && n < 20) begin
        @(negedge clock);
        n++;
      end
      wordIn    = W'($urandom);
      wordValid = 1'b1;
      @(posedge clock);
      #1;
      wordValid = 1'b0;
    end
    idle(10);

    // Randomised traffic with random gaps.
    for (int k = 0; k < 40; k++) begin
      send(W'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 9));
    end
    idle(20);

    // Reset during bit 3 of a word while a second word is pending.
    send(7'h5A);
    send(7'h33);
    wordValid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    nReset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("midreset_bitValid", bitValid, 1'b0);
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_dataOut", dataOut, 1'b1);
    chk("midreset_wordReady", wordReady, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    nReset = 1'b1;
    @(negedge clock);
    chk("postreset_wordReady", wordReady, 1'b1);
    idle(12);

    // WIDTH=1 instance: 1,0,1 back-to-back, then random bits.
    send1(1'b1);
    send1(1'b0);
    send1(1'b1);
    idle(4);
    for (int k = 0; k < 20; k++) begin
      send1(1'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(6);

    monEn = 1'b0;
    chk("queue_drained", exp_q.size() + exp1_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
